// File: rtl/ram_access_controller.sv
// ram_access_controller
//
// Bus initiator between the CPU datapath and the 512-byte RAM. Takes one
// byte/halfword/word load or store at a time, converts the CPU byte address
// into the RAM word base address plus the A offset, sequences the RAM enable,
// waits for done, and returns zero/sign-extended load data with a one-cycle
// acknowledge. Misaligned accesses, illegal sizes and a RAM that never
// completes are reported through cpu_err alongside cpu_ack.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   cpu_req           : request strobe, sampled only when the controller is free
//   cpu_rw            : 1 = load, 0 = store
//   cpu_size          : 00 byte, 01 halfword, 10 word, 11 illegal
//   cpu_signed        : sign-extend byte/halfword loads
//   cpu_addr          : byte address
//   cpu_wdata         : store data, right-justified
//   cpu_busy          : controller is handling a request
//   cpu_ack           : one-cycle completion pulse
//   cpu_err           : error flag, valid with cpu_ack
//   cpu_rdata         : last successful load result
//   mem_enable        : RAM enable
//   mem_read_write    : RAM readWrite (1 read, 0 write)
//   mem_address       : RAM word base address
//   mem_data_in       : RAM write data
//   mem_mas           : RAM access size
//   mem_a             : RAM byte offset within the word
//   mem_data_out      : RAM read data
//   mem_done          : RAM completion flag
module ram_access_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [8:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        mem_enable,
    output logic        mem_read_write,
    output logic [8:0]  mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_mas,
    output logic [1:0]  mem_a,
    input  logic [31:0] mem_data_out,
    input  logic        mem_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_FAULT
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic               r_pending;
    logic               r_rw;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [8:0]         r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               r_busy;
    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic               r_mem_enable;
    logic               r_mem_rw;
    logic [8:0]         r_mem_address;
    logic [31:0]        r_mem_data_in;
    logic [1:0]         r_mem_mas;
    logic [1:0]         r_mem_a;

    logic               w_accept;
    logic               w_fault;
    logic [31:0]        w_load;

    // A request is taken in IDLE, and also on the edge that leaves DONE/FAULT
    // so back-to-back transactions lose no cycle.
    assign w_accept = cpu_req &&
                      (((r_state == S_IDLE) && !r_pending) ||
                       (r_state == S_DONE) || (r_state == S_FAULT));

    assign w_fault = (r_size == 2'b11) ||
                     ((r_size == 2'b01) && r_addr[0]) ||
                     ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));

    always_comb begin
        w_load = mem_data_out;
        case (r_size)
            2'b00:   w_load = {{24{r_signed & mem_data_out[7]}},  mem_data_out[7:0]};
            2'b01:   w_load = {{16{r_signed & mem_data_out[15]}}, mem_data_out[15:0]};
            default: w_load = mem_data_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pending     <= 1'b0;
            r_rw          <= 1'b0;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wait_cnt    <= '0;
            r_busy        <= 1'b0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
            r_mem_enable  <= 1'b0;
            r_mem_rw      <= 1'b1;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_mas     <= 2'b00;
            r_mem_a       <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The captured request is classified one edge after capture;
                    // the chosen state's outputs are registered on entry.
                    if (r_pending) begin
                        r_pending <= 1'b0;
                        if (w_fault) begin
                            r_state <= S_FAULT;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state       <= S_SETUP;
                            r_mem_address <= {r_addr[8:2], 2'b00};
                            r_mem_a       <= ~r_addr[1:0];
                            r_mem_mas     <= r_size;
                            r_mem_rw      <= r_rw;
                            r_mem_data_in <= r_wdata;
                            r_mem_enable  <= 1'b0;
                        end
                    end else if (w_accept) begin
                        r_busy <= 1'b1;
                    end
                end

                S_SETUP: begin
                    r_state      <= S_ACCESS;
                    r_mem_enable <= 1'b1;
                    r_wait_cnt   <= '0;
                end

                S_ACCESS: begin
                    // done in the first enabled cycle may be left over from the
                    // previous access, so it only counts from wait_cnt >= 1.
                    if ((r_wait_cnt != '0) && mem_done) begin
                        r_state      <= S_DONE;
                        r_mem_enable <= 1'b0;
                        r_ack        <= 1'b1;
                        r_err        <= 1'b0;
                        if (r_rw) begin
                            r_rdata <= w_load;
                        end
                    end else if (r_wait_cnt == LAST_CNT) begin
                        r_state      <= S_DONE;
                        r_mem_enable <= 1'b0;
                        r_ack        <= 1'b1;
                        r_err        <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                S_DONE, S_FAULT: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= w_accept;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_mem_enable <= 1'b0;
                    r_ack        <= 1'b0;
                    r_err        <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase

            if (w_accept) begin
                r_pending <= 1'b1;
                r_rw      <= cpu_rw;
                r_size    <= cpu_size;
                r_signed  <= cpu_signed;
                r_addr    <= cpu_addr;
                r_wdata   <= cpu_wdata;
            end
        end
    end

    assign cpu_busy       = r_busy;
    assign cpu_ack        = r_ack;
    assign cpu_err        = r_err;
    assign cpu_rdata      = r_rdata;
    assign mem_enable     = r_mem_enable;
    assign mem_read_write = r_mem_rw;
    assign mem_address    = r_mem_address;
    assign mem_data_in    = r_mem_data_in;
    assign mem_mas        = r_mem_mas;
    assign mem_a          = r_mem_a;

endmodule

// File: tb/tb_ram_access_controller.sv
// Testbench for ram_access_controller: behavioural big-endian RAM model with
// selectable done behaviour, a shadow memory for expected load values, and a
// scoreboard of expected (err, rdata) pairs popped on every cpu_ack.
module tb_ram_access_controller;

    localparam int unsigned TO      = 16;
    localparam int unsigned RAM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_rw;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic        mem_enable;
    logic        mem_read_write;
    logic [8:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_mas;
    logic [1:0]  mem_a;
    logic [31:0] mem_data_out;
    logic        mem_done;

    always #5 clk = ~clk;

    ram_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_rw         (cpu_rw),
        .cpu_size       (cpu_size),
        .cpu_signed     (cpu_signed),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_busy       (cpu_busy),
        .cpu_ack        (cpu_ack),
        .cpu_err        (cpu_err),
        .cpu_rdata      (cpu_rdata),
        .mem_enable     (mem_enable),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_mas        (mem_mas),
        .mem_a          (mem_a),
        .mem_data_out   (mem_data_out),
        .mem_done       (mem_done)
    );

    // ---------------- counters and checker ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- RAM model ----------------
    // done_mode: 0 = done after RAM_LAT enabled cycles, 1 = always high, 2 = never
    int          done_mode = 1;
    int unsigned ecnt = 0;
    logic [7:0]  ram    [512];
    logic [7:0]  shadow [512];
    logic [8:0]  w_off;

    assign w_off    = mem_address + {7'd0, ~mem_a};
    assign mem_done = (done_mode == 1) ? 1'b1 :
                      (done_mode == 2) ? 1'b0 :
                      (mem_enable && (ecnt >= RAM_LAT));

    always_comb begin
        mem_data_out = '0;
        if (mem_enable && mem_read_write) begin
            case (mem_mas)
                2'b00:   mem_data_out = {24'hA5A5A5, ram[w_off]};
                2'b01:   mem_data_out = {16'h5A5A, ram[w_off], ram[w_off + 9'd1]};
                default: mem_data_out = {ram[w_off], ram[w_off + 9'd1],
                                         ram[w_off + 9'd2], ram[w_off + 9'd3]};
            endcase
        end
    end

    always @(posedge clk) begin
        ecnt <= mem_enable ? ecnt + 1 : 0;
        if (mem_enable && mem_done && !mem_read_write) begin
            case (mem_mas)
                2'b00: ram[w_off] <= mem_data_in[7:0];
                2'b01: begin
                    ram[w_off]        <= mem_data_in[15:8];
                    ram[w_off + 9'd1] <= mem_data_in[7:0];
                end
                default: begin
                    ram[w_off]        <= mem_data_in[31:24];
                    ram[w_off + 9'd1] <= mem_data_in[23:16];
                    ram[w_off + 9'd2] <= mem_data_in[15:8];
                    ram[w_off + 9'd3] <= mem_data_in[7:0];
                end
            endcase
        end
    end

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn, input logic [8:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = shadow[a];
        b1 = shadow[a + 9'd1];
        b2 = shadow[a + 9'd2];
        b3 = shadow[a + 9'd3];
        case (sz)
            2'b00:   return {{24{sgn & b0[7]}}, b0};
            2'b01:   return {{16{sgn & b0[7]}}, b0, b1};
            default: return {b0, b1, b2, b3};
        endcase
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [8:0] a, input logic [31:0] d);
        case (sz)
            2'b00: shadow[a] = d[7:0];
            2'b01: begin
                shadow[a]        = d[15:8];
                shadow[a + 9'd1] = d[7:0];
            end
            default: begin
                shadow[a]        = d[31:24];
                shadow[a + 9'd1] = d[23:16];
                shadow[a + 9'd2] = d[15:8];
                shadow[a + 9'd3] = d[7:0];
            end
        endcase
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rd = '0;

    always @(negedge clk) begin
        if (cpu_ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", {31'd0, cpu_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_err",   {31'd0, cpu_err}, {31'd0, e.err});
                check("ack_rdata", cpu_rdata, e.rdata);
            end
        end
    end

    // Snapshots of the RAM interface taken while a transaction runs.
    logic [8:0]  snap_addr;
    logic [1:0]  snap_a, snap_mas;
    logic        snap_rw, snap_en1, snap_en2, ack_en;
    logic [31:0] snap_din;

    // j counts edges after the sampling edge N; j=k is the cycle after edge N+k.
    task automatic issue(input logic rw, input logic [1:0] sz, input logic sgn,
                         input logic [8:0] a, input logic [31:0] wd, input bit b2b,
                         output int lat, output logic en_seen);
        exp_t e;
        bit   flt;
        flt   = (sz == 2'b11) || ((sz == 2'b01) && a[0]) ||
                ((sz == 2'b10) && (a[1:0] != 2'b00));
        e.err = flt || (done_mode == 2);
        if (!e.err) begin
            if (rw) exp_rd = ref_load(sz, sgn, a);
            else    ref_store(sz, a, wd);
        end
        e.rdata = exp_rd;
        sb.push_back(e);
        if (!b2b) @(negedge clk);
        cpu_rw = rw; cpu_size = sz; cpu_signed = sgn; cpu_addr = a; cpu_wdata = wd;
        cpu_req = 1'b1;
        @(posedge clk);
        lat = -1;
        en_seen = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (j == 0) cpu_req = 1'b0;
            if (mem_enable) en_seen = 1'b1;
            if (j == 1) begin
                snap_addr = mem_address; snap_a = mem_a; snap_mas = mem_mas;
                snap_rw = mem_read_write; snap_en1 = mem_enable; snap_din = mem_data_in;
            end
            if (j == 2) snap_en2 = mem_enable;
            if (cpu_ack) begin
                ack_en = mem_enable;
                lat = j;
                break;
            end
        end
        if (lat < 0) check("ack_wait_expired", {31'd0, cpu_ack}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int   lat;
    logic en_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_size = 2'b00;
        cpu_signed = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        check("rst_mem_rw",     {31'd0, mem_read_write}, 32'd1);
        check("rst_mem_addr",   {23'd0, mem_address}, 32'd0);
        check("rst_mem_din",    mem_data_in, 32'd0);
        check("rst_mem_mas_a",  {28'd0, mem_mas, mem_a}, 32'd0);
        check("rst_cpu_flags",  {29'd0, cpu_ack, cpu_err, cpu_busy}, 32'd0);
        check("rst_cpu_rdata",  cpu_rdata, 32'd0);
        reset = 1'b0;

        // Word store with done already high: ack in the cycle after edge N+4.
        done_mode = 1;
        issue(1'b0, 2'b10, 1'b0, 9'h00C, 32'hDEADBEEF, 1'b0, lat, en_seen);
        check("st_latency",  lat, 32'd4);
        check("st_addr",     {23'd0, snap_addr}, 32'h00C);
        check("st_a",        {30'd0, snap_a}, 32'd3);
        check("st_mas",      {30'd0, snap_mas}, 32'd2);
        check("st_rw",       {31'd0, snap_rw}, 32'd0);
        check("st_din",      snap_din, 32'hDEADBEEF);
        check("st_en_setup", {31'd0, snap_en1}, 32'd0);
        check("st_en_access",{31'd0, snap_en2}, 32'd1);
        check("st_en_ack",   {31'd0, ack_en}, 32'd0);

        // Word load, stale done must not shorten the access.
        issue(1'b1, 2'b10, 1'b0, 9'h00C, 32'h0, 1'b0, lat, en_seen);
        check("ldw_latency", lat, 32'd4);
        check("ldw_rw",      {31'd0, snap_rw}, 32'd1);

        // Byte loads, second one back-to-back.
        done_mode = 0;
        issue(1'b1, 2'b00, 1'b1, 9'h00D, 32'h0, 1'b0, lat, en_seen);
        check("ldb_a",       {30'd0, snap_a}, 32'd2);
        check("ldb_latency", lat, 32'd5);
        issue(1'b1, 2'b00, 1'b0, 9'h00D, 32'h0, 1'b1, lat, en_seen);
        check("b2b_en_gap",  {31'd0, snap_en1}, 32'd0);
        check("b2b_latency", lat, 32'd5);

        // Halfword loads.
        issue(1'b1, 2'b01, 1'b0, 9'h00E, 32'h0, 1'b0, lat, en_seen);
        check("ldh_a",   {30'd0, snap_a}, 32'd1);
        check("ldh_mas", {30'd0, snap_mas}, 32'd1);
        issue(1'b1, 2'b01, 1'b1, 9'h00E, 32'h0, 1'b1, lat, en_seen);

        // Faults: misaligned word/halfword, illegal size.
        issue(1'b1, 2'b10, 1'b0, 9'h00E, 32'h0, 1'b0, lat, en_seen);
        check("mis_w_latency", lat, 32'd1);
        check("mis_w_enable",  {31'd0, en_seen}, 32'd0);
        issue(1'b0, 2'b01, 1'b0, 9'h00D, 32'h1234, 1'b0, lat, en_seen);
        check("mis_h_latency", lat, 32'd1);
        check("mis_h_enable",  {31'd0, en_seen}, 32'd0);
        issue(1'b1, 2'b11, 1'b0, 9'h000, 32'h0, 1'b1, lat, en_seen);
        check("ill_latency",   lat, 32'd1);
        check("ill_enable",    {31'd0, en_seen}, 32'd0);

        // Timeout, then a normal access.
        done_mode = 2;
        issue(1'b1, 2'b10, 1'b0, 9'h00C, 32'h0, 1'b0, lat, en_seen);
        check("to_latency", lat, 2 + TO);
        check("to_en_fall", {31'd0, ack_en}, 32'd0);
        done_mode = 0;
        issue(1'b1, 2'b10, 1'b0, 9'h00C, 32'h0, 1'b0, lat, en_seen);
        check("after_to_latency", lat, 32'd5);

        // Random aligned store/load pairs.
        for (int k = 0; k < 8; k++) begin
            logic [1:0]  sz;
            logic [8:0]  a;
            logic [31:0] d;
            sz = 2'($urandom_range(0, 2));
            a  = 9'($urandom_range(0, 511));
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            d  = $urandom;
            issue(1'b0, sz, 1'b0, a, d, 1'b0, lat, en_seen);
            issue(1'b1, sz, k[0], a, 32'h0, 1'b1, lat, en_seen);
        end

        // Reset in the middle of a write access.
        done_mode = 2;
        @(negedge clk);
        cpu_rw = 1'b0; cpu_size = 2'b10; cpu_signed = 1'b0;
        cpu_addr = 9'h010; cpu_wdata = 32'h12345678; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int j = 0; j < 10 && !mem_enable; j++) @(negedge clk);
        check("rst_mid_en_before", {31'd0, mem_enable}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_enable", {31'd0, mem_enable}, 32'd0);
        check("rst_mid_flags",  {29'd0, cpu_ack, cpu_err, cpu_busy}, 32'd0);
        check("rst_mid_rw",     {31'd0, mem_read_write}, 32'd1);
        check("rst_mid_addr",   {23'd0, mem_address}, 32'd0);
        check("rst_mid_din",    mem_data_in, 32'd0);
        check("rst_mid_rdata",  cpu_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_rd = '0;
        repeat (5) @(negedge clk);
        check("rst_mid_no_ack", {31'd0, cpu_ack}, 32'd0);

        done_mode = 0;
        issue(1'b1, 2'b10, 1'b0, 9'h00C, 32'h0, 1'b0, lat, en_seen);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
